// File: rtl/aad_tile_loader.sv
// Ping-pong 8x8 tile assembler feeding the AAD pooling stage.
// One bank fills from the pixel stream while the other is held for the consumer.
module aad_tile_loader #(
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic             pix_ready,
  output logic [PIX_W-1:0] tile_out [0:7][0:7],
  output logic             tile_valid,
  input  logic             tile_ready,
  output logic [5:0]       fill_idx,
  output logic             sync_err,
  output logic [15:0]      tiles_done
);

  logic [63:0][PIX_W-1:0] bank [0:1];
  logic       wr_sel;
  logic       rd_sel;
  logic [1:0] bank_full;
  logic [1:0] full_nxt;
  logic [5:0] wr_idx;
  logic [5:0] wr_k;
  logic       accept;
  logic       take;
  logic       tile_end;

  assign pix_ready  = !rst && !bank_full[wr_sel];
  assign accept     = pix_valid && pix_ready;
  assign tile_valid = bank_full[rd_sel];
  assign take       = tile_valid && tile_ready;
  assign wr_k       = pix_sof ? 6'd0 : wr_idx;
  assign tile_end   = accept && (wr_k == 6'd63);
  assign fill_idx   = wr_idx;

  // Fill and drain always target different banks when both fire.
  always_comb begin
    full_nxt = bank_full;
    if (take)
      full_nxt[rd_sel] = 1'b0;
    if (tile_end)
      full_nxt[wr_sel] = 1'b1;
  end

  always_comb begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        tile_out[r][c] = bank[rd_sel][6'(r * 8 + c)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank[0]    <= '0;
      bank[1]    <= '0;
      wr_sel     <= 1'b0;
      rd_sel     <= 1'b0;
      bank_full  <= 2'b00;
      wr_idx     <= 6'd0;
      sync_err   <= 1'b0;
      tiles_done <= 16'd0;
    end else begin
      sync_err  <= accept && pix_sof && (wr_idx != 6'd0);
      bank_full <= full_nxt;
      if (accept) begin
        bank[wr_sel][wr_k] <= pix_in;
        wr_idx <= pix_sof ? 6'd1 : wr_idx + 6'd1;
      end
      if (tile_end)
        wr_sel <= ~wr_sel;
      if (take) begin
        rd_sel     <= ~rd_sel;
        tiles_done <= tiles_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_aad_tile_loader.sv
// Bench for aad_tile_loader: vector table, directed corner
// sequences and a random stream against a tile-queue model.
module tb_aad_tile_loader;

  typedef logic [63:0][7:0] tile_t;

  typedef struct {
    logic       r;
    logic       v;
    logic       s;
    logic [7:0] p;
    logic       tr;
    logic       e_rdy;
    logic       e_val;
    logic       e_err;
    logic [5:0] e_fill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pix_in = 8'd0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic        pix_ready;
  logic [7:0]  tile_out [0:7][0:7];
  logic        tile_valid;
  logic        tile_ready = 1'b0;
  logic [5:0]  fill_idx;
  logic        sync_err;
  logic [15:0] tiles_done;

  aad_tile_loader #(.PIX_W(8)) dut (
    .clk(clk), .rst(rst),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .pix_ready(pix_ready),
    .tile_out(tile_out), .tile_valid(tile_valid), .tile_ready(tile_ready),
    .fill_idx(fill_idx), .sync_err(sync_err), .tiles_done(tiles_done)
  );

  always #5 clk = ~clk;

  // Model: completed tiles wait in a FIFO of depth two.
  tile_t       mq[$];
  tile_t       mpart;
  int          mcnt;
  logic        merr;
  logic [15:0] mdone;
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic tile_t dut_tile();
    tile_t t;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        t[r*8+c] = tile_out[r][c];
    return t;
  endfunction

  function automatic tile_t pattern(input int base);
    tile_t t;
    for (int k = 0; k < 64; k++)
      t[k] = 8'(base + k);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, a, e);
  endtask

  task automatic chk_t(input string nm, input tile_t a, input tile_t e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, a, e);
  endtask

  task automatic cyc(input logic v, input logic s, input logic [7:0] p,
                     input logic tr, input logic r);
    logic rdy, acc, hs;
    pix_valid  = v;
    pix_sof    = s;
    pix_in     = p;
    tile_ready = tr;
    rst        = r;
    rdy = !r && (mq.size() < 2);
    acc = v && rdy;
    hs  = !r && (mq.size() > 0) && tr;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
      mpart = '0;
      mcnt  = 0;
      merr  = 1'b0;
      mdone = 16'd0;
    end else begin
      merr = 1'b0;
      if (hs) begin
        void'(mq.pop_front());
        mdone = mdone + 16'd1;
      end
      if (acc) begin
        if (s) begin
          merr  = (mcnt != 0);
          mpart = '0;
          mpart[0] = p;
          mcnt  = 1;
        end else begin
          mpart[mcnt] = p;
          mcnt++;
          if (mcnt == 64) begin
            mq.push_back(mpart);
            mcnt = 0;
          end
        end
      end
    end
    chk("pix_ready", 32'(pix_ready), 32'(!r && (mq.size() < 2)));
    chk("tile_valid", 32'(tile_valid), 32'(mq.size() > 0));
    chk("fill_idx", 32'(fill_idx), 32'(mcnt));
    chk("sync_err", 32'(sync_err), 32'(merr));
    chk("tiles_done", 32'(tiles_done), 32'(mdone));
    if (mq.size() > 0)
      chk_t("tile_out", dut_tile(), mq[0]);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic push(input int n, input int base, input logic first_sof);
    for (int i = 0; i < n; i++)
      cyc(1'b1, first_sof && (i == 0), 8'(base + i), 1'b0, 1'b0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{r:1, v:0, s:0, p:8'h00, tr:0, e_rdy:0, e_val:0, e_err:0, e_fill:0};
    tbl[1] = '{r:0, v:1, s:1, p:8'h05, tr:0, e_rdy:1, e_val:0, e_err:0, e_fill:1};
    tbl[2] = '{r:0, v:1, s:0, p:8'h06, tr:0, e_rdy:1, e_val:0, e_err:0, e_fill:2};
    tbl[3] = '{r:0, v:0, s:0, p:8'h99, tr:1, e_rdy:1, e_val:0, e_err:0, e_fill:2};
    tbl[4] = '{r:0, v:1, s:1, p:8'h07, tr:0, e_rdy:1, e_val:0, e_err:1, e_fill:1};
    tbl[5] = '{r:0, v:0, s:0, p:8'h00, tr:0, e_rdy:1, e_val:0, e_err:0, e_fill:1};
    tbl[6] = '{r:1, v:1, s:0, p:8'h11, tr:0, e_rdy:0, e_val:0, e_err:0, e_fill:0};
    tbl[7] = '{r:0, v:0, s:0, p:8'h00, tr:0, e_rdy:1, e_val:0, e_err:0, e_fill:0};

    mpart = '0; mcnt = 0; merr = 1'b0; mdone = 16'd0;
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
    chk("rst_fill", 32'(fill_idx), 32'd0);
    chk_t("rst_tile", dut_tile(), '0);

    foreach (tbl[i]) begin
      cyc(tbl[i].v, tbl[i].s, tbl[i].p, tbl[i].tr, tbl[i].r);
      chk($sformatf("vec%0d_rdy", i), 32'(pix_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_val", i), 32'(tile_valid), 32'(tbl[i].e_val));
      chk($sformatf("vec%0d_err", i), 32'(sync_err), 32'(tbl[i].e_err));
      chk($sformatf("vec%0d_fill", i), 32'(fill_idx), 32'(tbl[i].e_fill));
    end

    // Single tile, held then released
    do_reset();
    push(63, 0, 1'b1);
    chk("st_notyet", 32'(tile_valid), 32'd0);
    push(1, 63, 1'b0);
    chk("st_valid", 32'(tile_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
      chk_t("st_hold", dut_tile(), pattern(0));
    end
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    chk("st_drop", 32'(tile_valid), 32'd0);
    chk("st_done", 32'(tiles_done), 32'd1);

    // Two full banks stall the stream
    do_reset();
    push(64, 0, 1'b1);
    push(64, 64, 1'b1);
    chk("bp_rdy", 32'(pix_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
      chk("bp_fill", 32'(fill_idx), 32'd0);
      chk_t("bp_tileA", dut_tile(), pattern(0));
    end
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
    chk("bp_valid", 32'(tile_valid), 32'd1);
    chk_t("bp_tileB", dut_tile(), pattern(64));
    chk("bp_rdy2", 32'(pix_ready), 32'd1);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);

    // Full-rate stream, ack three cycles after valid
    do_reset();
    begin
      int idx, vcnt, guard;
      logic tr;
      idx = 0; vcnt = 0; guard = 0;
      while ((idx < 256 || tiles_done != 16'd4) && guard < 400) begin
        logic was_rdy, v;
        tr = tile_valid && (vcnt >= 3);
        v = (idx < 256);
        was_rdy = pix_ready;
        if (v) chk("fr_ready", 32'(was_rdy), 32'd1);
        cyc(v, v && (idx % 64 == 0), 8'(idx * 3 + 1), tr, 1'b0);
        if (v && was_rdy) idx++;
        if (tr) vcnt = 0;
        else if (tile_valid) vcnt++;
        guard++;
      end
      chk("fr_done", 32'(tiles_done), 32'd4);
    end

    // Resync mid-tile
    do_reset();
    push(20, 200, 1'b1);
    cyc(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
    chk("rs_err", 32'(sync_err), 32'd1);
    begin
      int errs;
      errs = 0;
      for (int i = 0; i < 63; i++) begin
        cyc(1'b1, 1'b0, 8'(i + 1), 1'b0, 1'b0);
        if (sync_err) errs++;
      end
      chk("rs_once", 32'(errs), 32'd0);
    end
    chk("rs_valid", 32'(tile_valid), 32'd1);
    chk("rs_00", 32'(tile_out[0][0]), 32'hAA);
    chk("rs_77", 32'(tile_out[7][7]), 32'd63);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);

    // Reset with a full bank and a partial tile
    do_reset();
    push(64, 0, 1'b1);
    push(30, 90, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("rm_valid", 32'(tile_valid), 32'd0);
    chk_t("rm_tile", dut_tile(), '0);
    chk("rm_fill", 32'(fill_idx), 32'd0);
    chk("rm_done", 32'(tiles_done), 32'd0);
    chk("rm_rdy", 32'(pix_ready), 32'd1);
    chk("rm_err", 32'(sync_err), 32'd0);
    push(64, 150, 1'b0);
    chk_t("rm_fresh", dut_tile(), pattern(150));
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0);

    // Completion of B on the same edge as A's handshake
    do_reset();
    push(64, 0, 1'b1);
    push(63, 100, 1'b1);
    cyc(1'b1, 1'b0, 8'd163, 1'b1, 1'b0);
    chk("sim_valid", 32'(tile_valid), 32'd1);
    chk_t("sim_tileB", dut_tile(), pattern(100));
    chk("sim_rdy", 32'(pix_ready), 32'd1);
    chk("sim_done", 32'(tiles_done), 32'd1);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++)
      cyc(($urandom % 4) != 0, ($urandom % 40) == 0, 8'($urandom),
          ($urandom % 3) == 0, ($urandom % 700) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
